// File: rtl/frame_scan_driver.sv
// frame_scan_driver: snapshots 16 frame words and scans them out column by column to a shift-register LED driver.
// Optional feature: define SCAN_BLANK_EN to blank columns while new data shifts in.
module frame_scan_driver #(
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [511:0] frames_in,
  output logic         sdo,
  output logic         sclk,
  output logic         latch,
  output logic [15:0]  col_sel,
  output logic         busy,
  output logic         pass_done
);

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_e;

  state_e           state_q;
  logic [511:0]     snap_q;
  logic [3:0]       idx_q;
  logic [4:0]       bit_q;
  logic             phase_q;
  logic [CNT_W-1:0] hold_q;
  logic             sdo_q;
  logic             sclk_q;
  logic             latch_q;
  logic [15:0]      col_q;
  logic             busy_q;
  logic             done_q;

  // Every output is set on the edge that enters the state it belongs to, so all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      sdo_q   <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          col_q <= '0;
          if (enable) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          // The first bit comes straight from frames_in, which is what the snapshot captures on this same edge.
          snap_q  <= frames_in;
          idx_q   <= '0;
          bit_q   <= 5'd31;
          phase_q <= 1'b0;
          sdo_q   <= frames_in[31];
          sclk_q  <= 1'b0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (!phase_q) begin
            sclk_q  <= 1'b1;
            phase_q <= 1'b1;
          end else if (bit_q == 5'd0) begin
            sclk_q  <= 1'b0;
            latch_q <= 1'b1;
            hold_q  <= CNT_W'(HOLD_CYCLES);
            state_q <= LATCH;
          end else begin
            sclk_q  <= 1'b0;
            phase_q <= 1'b0;
            bit_q   <= bit_q - 5'd1;
            sdo_q   <= snap_q[{idx_q, bit_q - 5'd1}];
          end
        end
        LATCH: begin
          col_q   <= 16'(1) << idx_q;
          state_q <= HOLD;
        end
        HOLD: begin
          if (hold_q == CNT_W'(1)) begin
            if (idx_q != 4'd15) begin
              idx_q   <= idx_q + 4'd1;
              bit_q   <= 5'd31;
              phase_q <= 1'b0;
              sdo_q   <= snap_q[{idx_q + 4'd1, 5'd31}];
              state_q <= SHIFT;
              if (BLANK) col_q <= '0;
            end else begin
              done_q <= 1'b1;
              if (enable) begin
                state_q <= LOAD;
                if (BLANK) col_q <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                col_q   <= '0;
              end
            end
          end else begin
            hold_q <= hold_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          col_q   <= '0;
        end
      endcase
    end
  end

  assign sdo       = sdo_q;
  assign sclk      = sclk_q;
  assign latch     = latch_q;
  assign col_sel   = col_q;
  assign busy      = busy_q;
  assign pass_done = done_q;

endmodule

// File: tb/tb_frame_scan_driver.sv
// tb_frame_scan_driver: randomized frames checked cycle by cycle against a pass-timing reference model.
// Honours SCAN_BLANK_EN so the column expectations follow the same build option as the design.
module tb_frame_scan_driver;
  localparam int HOLD       = 4;
  localparam int COL_PERIOD = 64 + 1 + HOLD;
  localparam int PASS_LEN   = 1 + 16 * COL_PERIOD;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [511:0] frames_in;
  logic         sdo;
  logic         sclk;
  logic         latch;
  logic [15:0]  col_sel;
  logic         busy;
  logic         pass_done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] framesDrv [16];

  always #5 clk = ~clk;

  frame_scan_driver #(.HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .frames_in(frames_in),
    .sdo(sdo),
    .sclk(sclk),
    .latch(latch),
    .col_sel(col_sel),
    .busy(busy),
    .pass_done(pass_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en);
    enable = en;
    for (int f = 0; f < 16; f++) frames_in[32*f +: 32] = framesDrv[f];
  endtask

  task automatic checkQuiet(input string tag, input logic expDone);
    checkOutput({tag, "_sclk"}, 32'(sclk), 32'd0);
    checkOutput({tag, "_latch"}, 32'(latch), 32'd0);
    checkOutput({tag, "_col"}, 32'(col_sel), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(pass_done), 32'(expDone));
  endtask

  // Reference: position in the pass decides everything; offset 0 is the LOAD cycle.
  task automatic runPass(input logic [15:0] prevCol, input logic prevDone, input int dropAt,
                         input int tearAt, input bit tearRandom);
    logic [31:0] snap [16];
    logic [31:0] serialWord;
    logic [15:0] shiftCol;
    logic [15:0] expCol;
    logic        expSdo;
    logic        expSclk;
    logic        expLatch;
    int          k;
    int          r;
    serialWord = '0;
    for (int o = 0; o < PASS_LEN; o++) begin
      @(negedge clk);
      if (o == 0) begin
        for (int f = 0; f < 16; f++) snap[f] = framesDrv[f];
        checkOutput("load_busy", 32'(busy), 32'd1);
        checkOutput("load_sclk", 32'(sclk), 32'd0);
        checkOutput("load_latch", 32'(latch), 32'd0);
        checkOutput("load_col", 32'(col_sel), BLANK ? 32'd0 : 32'(prevCol));
        checkOutput("load_done", 32'(pass_done), 32'(prevDone));
      end else begin
        k = (o - 1) / COL_PERIOD;
        r = (o - 1) % COL_PERIOD;
        shiftCol = BLANK ? 16'h0 : ((k == 0) ? prevCol : 16'(1) << (k - 1));
        if (r < 64) begin
          expSclk  = 1'(r % 2);
          expSdo   = snap[k][31 - r / 2];
          expLatch = 1'b0;
          expCol   = shiftCol;
        end else if (r == 64) begin
          expSclk  = 1'b0;
          expSdo   = snap[k][0];
          expLatch = 1'b1;
          expCol   = shiftCol;
        end else begin
          expSclk  = 1'b0;
          expSdo   = snap[k][0];
          expLatch = 1'b0;
          expCol   = 16'(1) << k;
        end
        checkOutput($sformatf("sdo@%0d", o), 32'(sdo), 32'(expSdo));
        checkOutput($sformatf("sclk@%0d", o), 32'(sclk), 32'(expSclk));
        checkOutput($sformatf("latch@%0d", o), 32'(latch), 32'(expLatch));
        checkOutput($sformatf("col@%0d", o), 32'(col_sel), 32'(expCol));
        checkOutput($sformatf("busy@%0d", o), 32'(busy), 32'd1);
        checkOutput($sformatf("done@%0d", o), 32'(pass_done), 32'd0);
        if (k == 0 && sclk === 1'b1) serialWord = {serialWord[30:0], sdo};
      end
      if (o == dropAt) applyStimulus(1'b0);
      if (o == tearAt) begin
        for (int f = 0; f < 16; f++) framesDrv[f] = tearRandom ? $urandom : 32'hFFFF_FFFF;
        applyStimulus(enable);
      end
    end
    checkOutput("serialFrame0", serialWord, snap[0]);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    for (int f = 0; f < 16; f++) framesDrv[f] = '0;
    applyStimulus(1'b0);
    #12;
    checkOutput("reset_sdo", 32'(sdo), 32'd0);
    checkQuiet("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkQuiet("idleAfterReset", 1'b0);
    end

    $display("[TB] pass A: known frame 0, enable dropped mid-pass, frames torn during frame 3");
    framesDrv[0] = 32'hA5A5_0001;
    for (int f = 1; f < 16; f++) framesDrv[f] = $urandom;
    applyStimulus(1'b1);
    runPass(16'h0, 1'b0, 300, 1 + 3 * COL_PERIOD + 10, 1'b0);
    @(negedge clk);
    checkQuiet("passAEnd", 1'b1);
    @(negedge clk);
    checkQuiet("idleA", 1'b0);
    @(negedge clk);
    checkQuiet("idleA2", 1'b0);

    $display("[TB] pass B then C back to back with enable held");
    applyStimulus(1'b1);
    runPass(16'h0, 1'b0, -1, 500, 1'b1);
    runPass(16'h8000, 1'b1, 800, -1, 1'b0);
    @(negedge clk);
    checkQuiet("passCEnd", 1'b1);
    @(negedge clk);
    checkQuiet("idleC", 1'b0);

    $display("[TB] asynchronous reset in the middle of SHIFT");
    applyStimulus(1'b1);
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midReset_sdo", 32'(sdo), 32'd0);
    checkQuiet("midReset", 1'b0);
    applyStimulus(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkQuiet("idleAfterMidReset", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_scan_driver.md
Name: frame_scan_driver

Overview:
- Downstream consumer of the 16-frame register file.
- Snapshots all 16 32-bit frame words at the start of each scan pass.
- For each frame in turn, serializes the word to an external shift-register display driver, strobes its latch, then enables that frame's column for a fixed hold time.
- Multiplexes a 16-column LED matrix.

Parameters:
- HOLD_CYCLES, 1000: clk cycles a column stays enabled after its latch; legal range 1 to 2^CNT_W-1.
- CNT_W, 16: width of the hold counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start/continue scanning; level-sensitive.
- frames_in  input  512  frame k on bits [32k+31:32k], k=0..15; the top level concatenates the register-file outputs.
- sdo  output  1  serial data to display driver, MSB first.
- sclk  output  1  serial shift clock; driver samples sdo on rising sclk.
- latch  output  1  one-clk pulse transferring the shifted word to the driver outputs.
- col_sel  output  16  one-hot column enable; bit k drives column k.
- busy  output  1  high in any state other than IDLE.
- pass_done  output  1  one-clk pulse at the end of the 16th column hold.

Behaviour:
- Reset: asynchronous on rst_n low. State IDLE; sdo, sclk, latch, col_sel, busy and pass_done all 0; snapshot, frame index, bit and hold counters cleared.
- States: IDLE, LOAD, SHIFT, LATCH, HOLD.
- IDLE:
  - enable=1 at a rising edge -> LOAD.
  - Otherwise stay in IDLE; col_sel=0.
- LOAD (1 clk):
  - Copy frames_in into a 512-bit snapshot; idx=0; bit counter=31 -> SHIFT.
  - frames_in is not sampled again until the next LOAD, so register-file updates mid-pass never tear a pass.
- SHIFT (64 clk per frame), 2 clks per bit:
  - Phase 0: sdo=snapshot[idx][bit], sclk=0.
  - Phase 1: sdo held, sclk=1.
  - After phase 1 of bit 0: sclk returns to 0 and sdo holds its last value -> LATCH.
- LATCH (1 clk):
  - latch=1; hold counter loaded with HOLD_CYCLES -> HOLD.
- HOLD (HOLD_CYCLES clk):
  - col_sel = 1<<idx; decrement counter.
  - Counter reaches 1 with idx<15: idx++; bit counter=31 -> SHIFT.
  - Counter reaches 1 with idx==15: pass_done=1 for the first cycle of the next state. Go to LOAD if enable=1 at that edge, else IDLE.
- Timing:
  - Per-column period: 64+1+HOLD_CYCLES clk.
  - Full pass from LOAD entry: 1+16*(65+HOLD_CYCLES) clk.
- Outputs are registered; no combinational path from inputs to outputs.
- Deasserting enable mid-pass does not abort: the pass completes, then the block returns to IDLE.
- Reasserting enable in the same cycle pass_done fires starts the next pass with no IDLE gap.
- col_sel is never more than one-hot.
- busy=1 from the LOAD cycle through the final HOLD cycle.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: col_sel forced to 0 in LOAD, SHIFT and LATCH, so columns are blanked while new data shifts in (no ghosting).
- Undefined: col_sel keeps the previous column's one-hot value through SHIFT and LATCH of the next frame, and changes only on HOLD entry. On the first frame of a pass from IDLE it is 0.

Test Plan:
1. Pulse rst_n low mid-SHIFT -> all outputs 0 immediately without a clk edge; busy=0; after release, no activity until enable=1.
2. HOLD_CYCLES=4; frame0=0xA5A50001, others 0; enable=1 -> sdo sampled on 32 sclk rising edges reads 0xA5A50001 MSB first; latch high exactly at clk 65 after LOAD; col_sel=0x0001 for 4 clks.
3. HOLD_CYCLES=4; frame k=k; enable held for one pass then dropped -> col_sel walks 0x0001,0x0002,...,0x8000; single pass_done pulse 1105 clks after LOAD; then IDLE with busy=0.
4. Change frames_in to all 0xFFFFFFFF during frame 3's SHIFT -> frames 3..15 still shift the original values; next pass shifts all ones.
5. Hold enable continuously -> pass_done every 1105 clks; LOAD follows immediately with no IDLE cycle.
6. Compile with SCAN_BLANK_EN -> col_sel==0 throughout every SHIFT/LATCH. Compile without it -> col_sel=0x0001 during frame 1's SHIFT.
